// File: rtl/vis_axis_packer.sv
// rtl/vis_axis_packer.sv - serialises correlator visibilities into header-prefixed byte frames
// Each frame: MAGIC, count[15:8], count[7:0], then re/im bytes MSB first per visibility.
module vis_axis_packer #(
  parameter int         WIDTH      = 32,
  parameter logic [7:0] MAGIC      = 8'hA5,
  parameter int         COUNT_BITS = 16,
  parameter int         MAX_VIS    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  input  logic                  s_tlast_i,
  input  logic [WIDTH-1:0]      s_re_i,
  input  logic [WIDTH-1:0]      s_im_i,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o,
  output logic [7:0]            m_tdata_o,
  output logic [COUNT_BITS-1:0] frame_count_o,
  output logic                  err_o
);
  localparam int BYTES = 2 * WIDTH / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int VC_W  = $clog2(MAX_VIS + 1);
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES - 1);
  localparam logic [VC_W-1:0] VIS_LIMIT = VC_W'(MAX_VIS);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_WAIT} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2*WIDTH-1:0]      r_cap;
  logic                    r_cap_last;
  logic [VC_W-1:0]         r_vis_cnt;
  logic [1:0]              r_hdr_idx;
  logic [BI_W-1:0]         r_byte_idx;
  logic [COUNT_BITS-1:0]   r_frame_count;
  logic                    r_err;

  logic                    w_m_hs;
  logic                    w_last_byte;
  logic                    w_eof;
  logic                    w_accept;
  logic                    w_frame_done;
  logic [7:0]              w_bytes [BYTES];

  // Byte 0 is the re MSB; the im LSB is the last byte of a visibility.
  for (genvar k = 0; k < BYTES; k++) begin : g_bytes
    assign w_bytes[k] = r_cap[2*WIDTH-1-8*k -: 8];
  end

  assign m_tvalid_o    = (r_state == S_HEAD) || (r_state == S_BODY);
  assign w_m_hs        = m_tvalid_o && m_tready_i;
  assign w_last_byte   = (r_byte_idx == LAST_BYTE);
  assign w_eof         = r_cap_last || (r_vis_cnt == VIS_LIMIT);
  assign w_frame_done  = (r_state == S_BODY) && w_m_hs && w_last_byte && w_eof;
  assign w_accept      = s_tvalid_i && s_tready_o;
  assign frame_count_o = r_frame_count;
  assign err_o         = r_err;

  always_comb begin
    w_state_nxt = r_state;
    s_tready_o  = 1'b0;
    m_tlast_o   = 1'b0;
    m_tdata_o   = 8'h00;
    case (r_state)
      S_IDLE: begin
        s_tready_o = 1'b1;
        if (s_tvalid_i) w_state_nxt = S_HEAD;
      end
      S_HEAD: begin
        case (r_hdr_idx)
          2'd0:    m_tdata_o = MAGIC;
          2'd1:    m_tdata_o = r_frame_count[15:8];
          default: m_tdata_o = r_frame_count[7:0];
        endcase
        if (w_m_hs && r_hdr_idx == 2'd2) w_state_nxt = S_BODY;
      end
      S_BODY: begin
        m_tdata_o = w_bytes[r_byte_idx];
        m_tlast_o = w_last_byte && w_eof;
        // The capture register frees up only as its last byte leaves, so refill without a bubble.
        if (w_m_hs && w_last_byte) begin
          if (w_eof) begin
            w_state_nxt = S_IDLE;
          end else begin
            s_tready_o = 1'b1;
            if (!s_tvalid_i) w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        s_tready_o = 1'b1;
        if (s_tvalid_i) w_state_nxt = S_BODY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst_i) s_tready_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_cap         <= '0;
      r_cap_last    <= 1'b0;
      r_vis_cnt     <= '0;
      r_hdr_idx     <= 2'd0;
      r_byte_idx    <= '0;
      r_frame_count <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cap      <= {s_re_i, s_im_i};
        r_cap_last <= s_tlast_i;
        r_byte_idx <= '0;
        r_vis_cnt  <= (r_state == S_IDLE) ? VC_W'(1) : r_vis_cnt + 1'b1;
      end else if (r_state == S_BODY && w_m_hs && !w_last_byte) begin
        r_byte_idx <= r_byte_idx + 1'b1;
      end
      if (r_state == S_HEAD && w_m_hs) begin
        r_hdr_idx <= (r_hdr_idx == 2'd2) ? 2'd0 : r_hdr_idx + 2'd1;
      end
      // Ending at the visibility limit without the source's last flag is a forced cut.
      if (w_frame_done) begin
        r_frame_count <= r_frame_count + 1'b1;
        if (!r_cap_last) r_err <= 1'b1;
      end
    end
  end

endmodule
